uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serial transmitter for the 16550-style UART. It is the transmit-side partner of the UART receiver.
//   Takes one parallel character from the TX holding logic and shifts it out on SOUT: start bit,
//   5-8 data bits (LSB first), optional parity, then 1/1.5/2 stop bits.
//   Bit timing comes from TXCLK, a one-CLK-wide enable pulse at OVERSAMPLE x baud rate from the baud generator.
// PARAMETERS
//   OVERSAMPLE  16  TXCLK pulses per bit period (>=4, even)
// PORTS
//   CLK         in   1  system clock; single clock domain, all logic on rising edge
//   RST         in   1  asynchronous, active-low reset
//   TXCLK       in   1  baud enable pulse, OVERSAMPLE x baud, one CLK wide
//   TXSTART     in   1  start request; DIN/config accepted when BUSY=0
//   DIN         in   8  character to send, LSB first; bits above word length ignored
//   WLS         in   2  word length select: 00=5, 01=6, 10=7, 11=8 bits
//   STB         in   1  0=1 stop bit; 1=2 stop bits (1.5 when WLS=00)
//   PEN         in   1  parity enable
//   EPS         in   1  even parity select (1=even, 0=odd)
//   SP          in   1  stick parity (parity bit = ~EPS)
//   BC          in   1  break control: forces SOUT=0 while high
//   SOUT        out  1  serial output, idle high
//   BUSY        out  1  high from accept until TXFINISHED cycle inclusive
//   TXFINISHED  out  1  one-CLK pulse at end of last stop bit
// BEHAVIOUR
//   Reset (RST=0, async): state=IDLE, SOUT=1, BUSY=0, TXFINISHED=0, tick/bit counters=0, shift reg=0.
//   Accept: TXSTART=1 && state==IDLE. On that edge, latch DIN, WLS, STB, PEN, EPS and SP into internal registers.
//     Parity is computed at accept, from the masked data bits.
//     Go to START, clear tick counter, set BUSY=1. TXSTART while BUSY=1 is ignored; nothing is queued.
//   Tick counter increments only on TXCLK=1. A bit ends on the CLK edge where TXCLK=1 and tick==OVERSAMPLE-1.
//     On that edge the counter wraps to 0 and the FSM advances.
//     Without TXCLK pulses the FSM holds its state indefinitely.
//   States and SOUT value (registered; SOUT shows the new state's bit from the cycle after the transition):
//     IDLE : SOUT=1. On accept -> START.
//     START: SOUT=0. On bit end -> DATA, with bitcnt=0.
//     DATA : SOUT=shreg[0]. On bit end: shift right, bitcnt++.
//            After the bit with bitcnt==4+WLS -> PAR if PEN=1, else STOP.
//     PAR  : SOUT=parity. On bit end -> STOP.
//     STOP : SOUT=1. Duration: OVERSAMPLE ticks if STB=0.
//            If STB=1: 2*OVERSAMPLE ticks when WLS!=00, or 3*OVERSAMPLE/2 ticks when WLS==00.
//            At the end: TXFINISHED=1 for one cycle, BUSY=0 on the next cycle, -> IDLE.
//   Parity (latched config):
//     SP=1: parity=~EPS.
//     SP=0, EPS=1 (even): parity = XOR of data bits.
//     SP=0, EPS=0 (odd):  parity = ~XOR of data bits.
//   BC: SOUT = (BC ? 0 : fsm_bit), combinational OR-free gating after the register.
//     The FSM, counters and TXFINISHED keep running unchanged under BC.
//   Config inputs changing mid-frame have no effect; only the values latched at accept are used.
//   Back-to-back: TXSTART high in the TXFINISHED cycle is ignored (state not yet IDLE).
//     The earliest accept is the cycle after.
//   TXCLK coinciding with accept: not counted toward the start bit.
//     The start bit therefore lasts exactly OVERSAMPLE TXCLK pulses.
//   Reset mid-frame: immediate return to idle values; the partial frame is abandoned with no TXFINISHED.
// TESTING
//   T1: TXCLK=1 every cycle, WLS=11, PEN=0, STB=0, DIN=8'h55, pulse TXSTART.
//       -> SOUT=0,1,0,1,0,1,0,1,0,1, each held 16 cycles. TXFINISHED pulses once, 160 cycles after accept.
//   T2: WLS=00, PEN=1, EPS=1, SP=0, DIN=8'hE7 (data 00111).
//       -> data bits 1,1,1,0,0 then parity=1, then one stop bit. Total frame 8 bits.
//   T3: WLS=00, STB=1 -> stop lasts 24 ticks. WLS=10, STB=1 -> stop lasts 32 ticks.
//       Check both TXFINISHED timings.
//   T4: SP=1, EPS=0, PEN=1, DIN=8'h00, WLS=11 -> parity bit = 1.
//       Odd parity with SP=0, DIN=8'h01 -> parity = 0.
//   T5: assert TXSTART repeatedly while BUSY, and change DIN/WLS mid-frame.
//       -> exactly one frame, with the originally latched values. BC=1 mid-frame -> SOUT=0,
//       but TXFINISHED timing is unchanged.
//   T6: drop RST in the middle of the DATA state -> SOUT=1, BUSY=0 immediately, no TXFINISHED.
//       After release, a new TXSTART sends a full, correct frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// 16550-style UART transmit serializer: start bit, 5-8 data bits LSB first,
// optional parity, 1/1.5/2 stop bits, timed by an OVERSAMPLE x baud enable.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TXCLK,
  input  logic       TXSTART,
  input  logic [7:0] DIN,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       SOUT,
  output logic       BUSY,
  output logic       TXFINISHED
);

  localparam int TW = $clog2(2 * OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_last;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    wls_q, wls_d;
  logic          stb_q, stb_d;
  logic          pen_q, pen_d;
  logic          par_q, par_d;
  logic          sout_q, sout_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic [7:0]    din_masked;
  logic          bit_end;

  function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [1:0] w);
    case (w)
      2'b00:   mask_data = d & 8'h1F;
      2'b01:   mask_data = d & 8'h3F;
      2'b10:   mask_data = d & 8'h7F;
      default: mask_data = d;
    endcase
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic eps, input logic sp);
    if (sp) parity_bit = ~eps;
    else    parity_bit = eps ? ^d : ~(^d);
  endfunction

  // Last tick index of the stop period; 1.5 stop bits only exist for 5-bit words.
  function automatic logic [TW-1:0] stop_last(input logic stb, input logic [1:0] w);
    if (!stb)          stop_last = TW'(OVERSAMPLE - 1);
    else if (w == 2'b00) stop_last = TW'(3 * OVERSAMPLE / 2 - 1);
    else               stop_last = TW'(2 * OVERSAMPLE - 1);
  endfunction

  always_comb begin
    din_masked = mask_data(DIN, WLS);
    tick_last  = (state_q == STOP) ? stop_last(stb_q, wls_q) : TW'(OVERSAMPLE - 1);
    bit_end    = TXCLK && (tick_q == tick_last);

    state_d  = state_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    wls_d    = wls_q;
    stb_d    = stb_q;
    pen_d    = pen_q;
    par_d    = par_q;
    fin_d    = 1'b0;

    // IDLE and DONE never count, so a TXCLK coinciding with accept is discarded.
    if (TXCLK && (state_q inside {START, DATA, PAR, STOP}))
      tick_d = bit_end ? '0 : tick_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (TXSTART) begin
          state_d = START;
          tick_d  = '0;
          shreg_d = din_masked;
          wls_d   = WLS;
          stb_d   = STB;
          pen_d   = PEN;
          par_d   = parity_bit(din_masked, EPS, SP);
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d  = {1'b0, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd4 + {1'b0, wls_q})
            state_d = pen_q ? PAR : STOP;
        end
      end
      PAR: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shreg_d[0];
      PAR:     sout_d = par_q;
      default: sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      wls_q    <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      sout_q   <= 1'b1;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      wls_q    <= wls_d;
      stb_q    <= stb_d;
      pen_q    <= pen_d;
      par_q    <= par_d;
      sout_q   <= sout_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
    end
  end

  // Break gates the registered line without disturbing frame timing.
  assign SOUT       = sout_q & ~BC;
  assign BUSY       = busy_q;
  assign TXFINISHED = fin_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: driver queues expected frames, monitor
// samples SOUT at bit centres and checks TXFINISHED/BUSY timing.
module tb_uart_transmitter;

  localparam int OS = 16;

  logic       CLK = 1'b0;
  logic       RST, TXCLK, TXSTART;
  logic [7:0] DIN;
  logic [1:0] WLS;
  logic       STB, PEN, EPS, SP, BC;
  logic       SOUT, BUSY, TXFINISHED;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] bits;
    int          nb;
    int          fin;
    bit          abort;
  } exp_t;

  exp_t q[$];

  uart_transmitter #(.OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .TXCLK(TXCLK), .TXSTART(TXSTART), .DIN(DIN),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .SOUT(SOUT), .BUSY(BUSY), .TXFINISHED(TXFINISHED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  bit   in_frame = 0;
  bit   busy_prev = 0;
  bit   rst_prev = 1;
  bit   post = 0;
  int   cyc = 0;
  exp_t cur;

  always @(negedge CLK) begin
    if (!RST) begin
      if (rst_prev) begin
        chk("reset_sout", int'(SOUT), 1);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_fin", int'(TXFINISHED), 0);
        if (in_frame) chk("abort_expected", int'(cur.abort), 1);
      end
      in_frame  = 0;
      post      = 0;
      rst_prev  = 0;
      busy_prev = 0;
    end else begin
      rst_prev = 1;
      if (post) begin
        chk("busy_after_fin", int'(BUSY), 0);
        post = 0;
      end
      if (in_frame) begin
        cyc++;
        if ((cyc % OS) == OS / 2 && (cyc / OS) < cur.nb)
          chk($sformatf("bit%0d", cyc / OS), int'(SOUT), int'(cur.bits[cyc / OS]));
        if (TXFINISHED) begin
          chk("fin_latency", cyc, cur.fin);
          chk("busy_at_fin", int'(BUSY), 1);
          in_frame = 0;
          post = 1;
        end else if (cyc > cur.fin + 8) begin
          chk("fin_timeout", cyc, cur.fin);
          in_frame = 0;
        end
      end else if (BUSY && !busy_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          cur = q.pop_front();
          in_frame = 1;
          cyc = 0;
        end
      end else if (TXFINISHED) begin
        chk("spurious_fin", 1, 0);
      end
      busy_prev = BUSY;
    end
  end

  // Driver
  task automatic start_frame(input logic [7:0] d, input logic [1:0] w, input logic stb_i,
                             input logic pen_i, input logic eps_i, input logic sp_i,
                             input logic [15:0] bits, input int nb, input int fin, input bit ab);
    exp_t e;
    @(posedge CLK); #1;
    DIN = d; WLS = w; STB = stb_i; PEN = pen_i; EPS = eps_i; SP = sp_i;
    e.bits = bits; e.nb = nb; e.fin = fin; e.abort = ab;
    q.push_back(e);
    TXSTART = 1'b1;
    @(posedge CLK); #1;
    TXSTART = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (BUSY && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (BUSY) chk("busy_timeout", 1, 0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; TXCLK = 1'b1; TXSTART = 1'b0; DIN = '0; WLS = '0;
    STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0; BC = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);

    // 8N1, 0x55
    start_frame(8'h55, 2'b11, 0, 0, 0, 0, 16'h02AA, 10, 160, 0); wait_done();
    // 5 bits, even parity, 0xE7 -> 1,1,1,0,0 p=1
    start_frame(8'hE7, 2'b00, 0, 1, 1, 0, 16'h00CE, 8, 128, 0); wait_done();
    // 1.5 stop bits with 5-bit word
    start_frame(8'h0A, 2'b00, 1, 0, 0, 0, 16'h0054, 7, 120, 0); wait_done();
    // 2 stop bits with 7-bit word
    start_frame(8'hC3, 2'b10, 1, 0, 0, 0, 16'h0186, 9, 160, 0); wait_done();
    // stick parity with EPS=0 -> parity 1
    start_frame(8'h00, 2'b11, 0, 1, 0, 1, 16'h0600, 11, 176, 0); wait_done();
    // odd parity of 0x01 -> 0
    start_frame(8'h01, 2'b11, 0, 1, 0, 0, 16'h0402, 11, 176, 0); wait_done();

    // Retrigger and config changes mid-frame, break over data bits 0..2
    start_frame(8'hA5, 2'b11, 0, 0, 0, 0, 16'h0340, 10, 160, 0);
    repeat (20) @(posedge CLK);
    #1;
    BC = 1'b1; TXSTART = 1'b1; DIN = 8'h00; WLS = 2'b00; PEN = 1'b1; STB = 1'b1;
    repeat (40) @(posedge CLK);
    #1 BC = 1'b0;
    repeat (80) @(posedge CLK);
    #1;
    TXSTART = 1'b0; WLS = 2'b11; PEN = 1'b0; STB = 1'b0;
    wait_done();

    // Back-to-back: request during the TXFINISHED cycle, held one more cycle
    start_frame(8'hF0, 2'b11, 0, 0, 0, 0, 16'h03E0, 10, 160, 0);
    begin
      int n = 0;
      while (!TXFINISHED && n < 300) begin
        @(posedge CLK); #1;
        n++;
      end
      if (!TXFINISHED) chk("b2b_fin_timeout", 1, 0);
    end
    begin
      exp_t e;
      e.bits = 16'h021E; e.nb = 10; e.fin = 160; e.abort = 0;
      q.push_back(e);
    end
    DIN = 8'h0F; TXSTART = 1'b1;
    repeat (2) @(posedge CLK);
    #1 TXSTART = 1'b0;
    wait_done();

    // Reset in the middle of the data bits
    start_frame(8'h3C, 2'b11, 0, 0, 0, 0, 16'h0000, 3, 9999, 1);
    repeat (50) @(posedge CLK);
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (30) @(posedge CLK);
    start_frame(8'h81, 2'b11, 0, 1, 1, 0, 16'h0502, 11, 176, 0); wait_done();

    repeat (20) @(posedge CLK);
    chk("queue_empty", q.size(), 0);
    chk("monitor_idle", int'(in_frame), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
